// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the serial instruction-memory loader.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
        ST_CHK     = 3'd5,
        ST_DONE    = 3'd6
    } state_e;

    localparam logic [15:0] DEF_BASE_ADDR = 16'h0000;
    localparam int          DEF_MAX_WORDS = 128;

    function automatic logic is_accepting(input state_e s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA_HI) ||
               (s == ST_DATA_LO) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-RAM write port of the program loader.
interface prog_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// Serial program loader: length header, big-endian words, XOR checksum; writes
// instruction RAM at BASE_ADDR + 2*i and holds the CPU for the whole load.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int          MAX_WORDS = DEF_MAX_WORDS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    prog_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          err
);

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_e      state_q, state_d;
    logic [7:0]  len_hi_q, len_hi_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  chk_q, chk_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        err_q, err_d;

    logic        byte_ready;
    logic        xfer;
    logic [15:0] len_w;

    assign byte_ready = is_accepting(state_q);
    assign xfer       = bus.byte_valid && byte_ready;
    assign len_w      = {len_hi_q, bus.byte_data};

    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        hi_d        = hi_q;
        chk_d       = chk_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;

        // Checksum covers every accepted byte up to, but not including, CHK.
        if (xfer && state_q != ST_CHK) begin
            chk_d = chk_q ^ bus.byte_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LEN_HI;
                    err_d   = 1'b0;
                    chk_d   = 8'h00;
                    addr_d  = BASE_ADDR;
                end
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    len_hi_d = bus.byte_data;
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    cnt_d = len_w;
                    if ({1'b0, len_w} > MAX_W) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (len_w == 16'h0000) begin
                        state_d = ST_CHK;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: begin
                if (xfer) begin
                    hi_d    = bus.byte_data;
                    state_d = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (xfer) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = {hi_q, bus.byte_data};
                    addr_d      = addr_q + 16'd2;
                    cnt_d       = cnt_q - 16'd1;
                    state_d     = (cnt_q == 16'd1) ? ST_CHK : ST_DATA_HI;
                end
            end
            ST_CHK: begin
                if (xfer) begin
                    err_d   = (bus.byte_data != chk_q);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_hi_q    <= 8'h00;
            hi_q        <= 8'h00;
            chk_q       <= 8'h00;
            cnt_q       <= 16'h0000;
            addr_q      <= BASE_ADDR;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_hi_q    <= len_hi_d;
            hi_q        <= hi_d;
            chk_q       <= chk_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
        end
    end

    assign bus.byte_ready = byte_ready;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign cpu_hold       = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DONE);
    assign err            = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (base 0x0000 and 0x0100) fed the same stream,
// checked against a stream/address model built from the load format rules.
module tb_prog_loader;

    typedef struct packed {
        logic        d;
        logic [15:0] a;
        logic [15:0] w;
        logic [31:0] c;
    } rec_t;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       vld   = 1'b0;
    logic [7:0] dat   = 8'h00;
    logic       hold0, done0, err0, hold1, done1, err1;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   dn0 = 0, dn1 = 0, hold_drop = 0, overlap = 0;
    bit   in_load = 1'b0;
    rec_t got[$];
    rec_t exp_q[$];
    int   xcyc[$];
    int   g0, d0_base, d1_base, hd_base, ov_base;

    always #5 clk = ~clk;

    prog_loader_if bus0 ();
    prog_loader_if bus1 ();

    assign bus0.byte_valid = vld;
    assign bus0.byte_data  = dat;
    assign bus1.byte_valid = vld;
    assign bus1.byte_data  = dat;

    prog_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(128)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .bus(bus0.slave),
        .cpu_hold(hold0), .done(done0), .err(err0)
    );

    prog_loader #(.BASE_ADDR(16'h0100), .MAX_WORDS(128)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .bus(bus1.slave),
        .cpu_hold(hold1), .done(done1), .err(err1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus0.mem_we) got.push_back(rec_t'{1'b0, bus0.mem_addr, bus0.mem_wdata, 32'(cyc)});
        if (bus1.mem_we) got.push_back(rec_t'{1'b1, bus1.mem_addr, bus1.mem_wdata, 32'(cyc)});
        if (done0) dn0 <= dn0 + 1;
        if (done1) dn1 <= dn1 + 1;
        if (in_load && (!hold0 || !hold1)) hold_drop <= hold_drop + 1;
        if ((done0 && bus0.mem_we) || (done1 && bus1.mem_we)) overlap <= overlap + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [7:0] s[$], input int gap_mode, input int start_at);
        int i = 0;
        int budget = 0;
        bit x;
        xcyc.delete();
        while (i < s.size() && budget < 4000) begin
            case (gap_mode)
                1:       vld = (budget % 2 == 0);
                2:       vld = ($urandom_range(0, 2) != 0);
                default: vld = 1'b1;
            endcase
            dat   = s[i];
            start = (i == start_at);
            @(negedge clk);
            x = vld && bus0.byte_ready;
            @(posedge clk); #1;
            if (x) begin
                xcyc.push_back(cyc);
                i++;
            end
            budget++;
        end
        vld   = 1'b0;
        start = 1'b0;
        if (i != s.size()) begin
            n_err++;
            $display("FAIL stream_timeout: sent %0d bytes want %0d", i, s.size());
        end
    endtask

    task automatic start_load();
        g0      = got.size();
        d0_base = dn0;
        d1_base = dn1;
        hd_base = hold_drop;
        ov_base = overlap;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        in_load = 1'b1;
    endtask

    // Model: word i lands at base + 2*i, strobed in the cycle after its low byte (stream byte 3+2i).
    task automatic expect_writes(input logic [15:0] w[$]);
        exp_q.delete();
        for (int i = 0; i < w.size(); i++) begin
            for (int d = 0; d < 2; d++) begin
                logic [15:0] base;
                int          c;
                base = (d == 1) ? 16'h0100 : 16'h0000;
                c    = (3 + 2 * i < xcyc.size()) ? xcyc[3 + 2 * i] : -1;
                exp_q.push_back(rec_t'{1'(d), base + 16'(2 * i), w[i], 32'(c)});
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({bus0.byte_ready, bus0.mem_we, bus0.mem_addr, bus0.mem_wdata, hold0, done0, err0} !== 37'b0) begin
            n_err++;
            $display("FAIL reset_dut0: got rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b want all 0",
                     bus0.byte_ready, bus0.mem_we, bus0.mem_addr, bus0.mem_wdata, hold0, done0, err0);
        end
        n_vec++;
        if ({bus1.byte_ready, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata, hold1, done1, err1} !== 37'b0) begin
            n_err++;
            $display("FAIL reset_dut1: got rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b want all 0",
                     bus1.byte_ready, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata, hold1, done1, err1);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        for (int k = 0; k < 5; k++) begin
            logic [7:0]  s[$];
            logic [15:0] w[$];
            logic        e;
            int          gm;
            int          sa;
            s.delete();
            w.delete();
            gm = 0;
            sa = -1;
            case (k)
                0: begin s = '{8'h00, 8'h02, 8'h81, 8'h02, 8'h82, 8'h01, 8'h02}; w = '{16'h8102, 16'h8201}; e = 1'b0; end
                1: begin s = '{8'h00, 8'h00, 8'h00}; e = 1'b0; end
                2: begin s = '{8'h00, 8'h01, 8'h80, 8'h01, 8'hFF}; w = '{16'h8001}; e = 1'b1; end
                3: begin s = '{8'h00, 8'h02, 8'h81, 8'h02, 8'h82, 8'h01, 8'h02}; w = '{16'h8102, 16'h8201};
                         e = 1'b0; gm = 1; sa = 4; end
                default: begin s = '{8'h00, 8'h81}; e = 1'b1; end
            endcase
            start_load();
            n_vec++;
            if ({bus0.byte_ready, hold0, bus1.byte_ready, hold1} !== 4'hF) begin
                n_err++;
                $display("FAIL start_accept[%0d]: got rdy/hold=%b%b%b%b want 1111", k,
                         bus0.byte_ready, hold0, bus1.byte_ready, hold1);
            end
            drive(s, gm, sa);
            expect_writes(w);
            n_vec++;
            if ({done0, done1, err0, err1} !== {2'b11, e, e}) begin
                n_err++;
                $display("FAIL end_status[%0d]: got done=%b%b err=%b%b want done=11 err=%b%b",
                         k, done0, done1, err0, err1, e, e);
            end
            @(posedge clk); #1;
            in_load = 1'b0;
            n_vec++;
            if ({done0, done1, bus0.byte_ready, bus1.byte_ready, hold0, hold1} !== 6'b0) begin
                n_err++;
                $display("FAIL idle_after[%0d]: got done=%b%b rdy=%b%b hold=%b%b want all 0", k,
                         done0, done1, bus0.byte_ready, bus1.byte_ready, hold0, hold1);
            end
            n_vec++;
            if (got.size() - g0 != exp_q.size()) begin
                n_err++;
                $display("FAIL write_count[%0d]: got %0d want %0d", k, got.size() - g0, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && g0 + i < got.size(); i++) begin
                n_vec++;
                if (got[g0 + i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL write[%0d.%0d]: got dut%0d %h=%h @%0d want dut%0d %h=%h @%0d", k, i,
                             got[g0 + i].d, got[g0 + i].a, got[g0 + i].w, got[g0 + i].c,
                             exp_q[i].d, exp_q[i].a, exp_q[i].w, exp_q[i].c);
                end
            end
            n_vec++;
            if (dn0 - d0_base != 1 || dn1 - d1_base != 1 || hold_drop != hd_base || overlap != ov_base) begin
                n_err++;
                $display("FAIL pulse_hold[%0d]: got done=%0d/%0d hold_drops=%0d overlaps=%0d want 1/1 0 0", k,
                         dn0 - d0_base, dn1 - d1_base, hold_drop - hd_base, overlap - ov_base);
            end
        end
    endtask

    task automatic test_sticky_err();
        logic [7:0] s[$];
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({err0, err1} !== 2'b11) begin
            n_err++;
            $display("FAIL err_sticky: got %b%b want 11", err0, err1);
        end
        start_load();
        n_vec++;
        if ({err0, err1} !== 2'b00) begin
            n_err++;
            $display("FAIL err_clear_on_start: got %b%b want 00", err0, err1);
        end
        s = '{8'h00, 8'h00, 8'h00};
        drive(s, 0, -1);
        @(posedge clk); #1;
        in_load = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0]  s[$];
        logic [15:0] w[$];
        start_load();
        s = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
        drive(s, 0, -1);
        vld = 1'b1;
        dat = 8'h44;
        rst = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        vld     = 1'b0;
        in_load = 1'b0;
        n_vec++;
        if ({bus0.byte_ready, bus0.mem_we, bus0.mem_addr, bus0.mem_wdata, hold0, done0, err0} !== 37'b0) begin
            n_err++;
            $display("FAIL rst_mid_dut0: got rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b want all 0",
                     bus0.byte_ready, bus0.mem_we, bus0.mem_addr, bus0.mem_wdata, hold0, done0, err0);
        end
        n_vec++;
        if ({bus1.byte_ready, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata, hold1, done1, err1} !== 37'b0) begin
            n_err++;
            $display("FAIL rst_mid_dut1: got rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b want all 0",
                     bus1.byte_ready, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata, hold1, done1, err1);
        end
        repeat (2) @(posedge clk);
        #1;
        w = '{16'h1122};
        expect_writes(w);
        n_vec++;
        if (got.size() - g0 != exp_q.size()) begin
            n_err++;
            $display("FAIL rst_mid_writes: got %0d want %0d", got.size() - g0, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && g0 + i < got.size(); i++) begin
            n_vec++;
            if (got[g0 + i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL rst_mid_write[%0d]: got %h=%h want %h=%h", i,
                         got[g0 + i].a, got[g0 + i].w, exp_q[i].a, exp_q[i].w);
            end
        end
        start_load();
        s = '{8'h00, 8'h02, 8'h81, 8'h02, 8'h82, 8'h01, 8'h02};
        drive(s, 0, -1);
        w = '{16'h8102, 16'h8201};
        expect_writes(w);
        n_vec++;
        if ({done0, done1, err0, err1} !== 4'b1100) begin
            n_err++;
            $display("FAIL reload_status: got done=%b%b err=%b%b want 1100", done0, done1, err0, err1);
        end
        @(posedge clk); #1;
        in_load = 1'b0;
        n_vec++;
        if (got.size() - g0 != exp_q.size()) begin
            n_err++;
            $display("FAIL reload_writes: got %0d want %0d", got.size() - g0, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && g0 + i < got.size(); i++) begin
            n_vec++;
            if (got[g0 + i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL reload_write[%0d]: got dut%0d %h=%h @%0d want dut%0d %h=%h @%0d", i,
                         got[g0 + i].d, got[g0 + i].a, got[g0 + i].w, got[g0 + i].c,
                         exp_q[i].d, exp_q[i].a, exp_q[i].w, exp_q[i].c);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 14; k++) begin
            logic [7:0]  s[$];
            logic [15:0] w[$];
            logic [15:0] ww;
            logic [7:0]  c;
            logic        e;
            int          n;
            int          gm;
            int          sa;
            s.delete();
            w.delete();
            case ($urandom_range(0, 9))
                0:       n = 0;
                1:       n = 128;
                2:       n = 129 + $urandom_range(0, 65000);
                default: n = $urandom_range(1, 6);
            endcase
            s.push_back(8'(n >> 8));
            s.push_back(8'(n));
            if (n > 128) begin
                e = 1'b1;
            end else begin
                for (int i = 0; i < n; i++) begin
                    ww = 16'($urandom);
                    w.push_back(ww);
                    s.push_back(ww[15:8]);
                    s.push_back(ww[7:0]);
                end
                c = 8'h00;
                foreach (s[j]) c = c ^ s[j];
                e = ($urandom_range(0, 3) == 0);
                s.push_back(e ? (c ^ 8'($urandom_range(1, 255))) : c);
            end
            gm = $urandom_range(0, 2);
            sa = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 5) : -1;
            start_load();
            drive(s, gm, sa);
            expect_writes(w);
            n_vec++;
            if ({done0, done1, err0, err1} !== {2'b11, e, e}) begin
                n_err++;
                $display("FAIL rnd_status[%0d] n=%0d: got done=%b%b err=%b%b want done=11 err=%b%b",
                         k, n, done0, done1, err0, err1, e, e);
            end
            @(posedge clk); #1;
            in_load = 1'b0;
            n_vec++;
            if ({done0, done1, bus0.byte_ready, bus1.byte_ready, hold0, hold1} !== 6'b0) begin
                n_err++;
                $display("FAIL rnd_idle[%0d]: got done=%b%b rdy=%b%b hold=%b%b want all 0", k,
                         done0, done1, bus0.byte_ready, bus1.byte_ready, hold0, hold1);
            end
            n_vec++;
            if (got.size() - g0 != exp_q.size()) begin
                n_err++;
                $display("FAIL rnd_count[%0d] n=%0d: got %0d want %0d", k, n, got.size() - g0, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && g0 + i < got.size(); i++) begin
                n_vec++;
                if (got[g0 + i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL rnd_write[%0d.%0d]: got dut%0d %h=%h @%0d want dut%0d %h=%h @%0d", k, i,
                             got[g0 + i].d, got[g0 + i].a, got[g0 + i].w, got[g0 + i].c,
                             exp_q[i].d, exp_q[i].a, exp_q[i].w, exp_q[i].c);
                end
            end
            n_vec++;
            if (dn0 - d0_base != 1 || dn1 - d1_base != 1 || hold_drop != hd_base || overlap != ov_base) begin
                n_err++;
                $display("FAIL rnd_pulse_hold[%0d]: got done=%0d/%0d hold_drops=%0d overlaps=%0d want 1/1 0 0", k,
                         dn0 - d0_base, dn1 - d1_base, hold_drop - hd_base, overlap - ov_base);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_sticky_err();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
